// File: rtl/frame_builder.sv
// frame_builder: parametrised sender-side framer.
// Generates a framed byte stream of NUM_ROWS x NUM_COLS bytes per frame:
// overhead columns, client payload pulled through a valid/ready handshake,
// and one trailing stuff column per row.
// Optional feature macro: FRAME_BIP8_EN. When defined, the XOR of every
// accepted payload byte of a frame is carried in row 0, col 8 of the next frame.
// Without it, that byte is 0x00 and no accumulator is built.
//
// Handshake: o_pyld_ready is a pure function of state (high only in PYLD).
// A payload byte transfers on a rising clock edge where both
// i_pyld_data_valid and o_pyld_ready are high. The framer never consumes data
// outside PYLD, and ready never looks at valid.
module frame_builder #(
   parameter int NUM_ROWS = 4,
   parameter int NUM_COLS = 1041,
   parameter int OH_COLS  = 16,
   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
   localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_arq_en,
   input  logic [7:0]       i_pyld_data,
   input  logic             i_pyld_data_valid,
   output logic             o_pyld_ready,
   output logic [7:0]       o_frame_data,
   output logic             o_frame_data_valid,
   output logic             o_frame_data_fas,
   output logic             o_frame_sof,
   output logic [ROW_W-1:0] o_row_cnt,
   output logic [COL_W-1:0] o_col_cnt,
   output logic [7:0]       o_mfas,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OH    = 2'd1,
      ST_PYLD  = 2'd2,
      ST_STUFF = 2'd3
   } state_t;

   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);
   localparam logic [COL_W-1:0] OH_LAST   = COL_W'(OH_COLS - 1);
   localparam logic [COL_W-1:0] PYLD_LAST = COL_W'(NUM_COLS - 2);

   localparam logic [7:0] FAS_A = 8'hF6;
   localparam logic [7:0] FAS_B = 8'h28;

   // Position of the next byte to be emitted.
   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [7:0]       mfas_q, mfas_d;

   // Registered output stage.
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             fas_q, fas_d;
   logic             sof_q, sof_d;
   logic [ROW_W-1:0] orow_q, orow_d;
   logic [COL_W-1:0] ocol_q, ocol_d;

   logic             pyld_ready;
   logic             accept;
   logic             emit;
   logic             frame_end;
   logic [7:0]       oh_byte;
   logic [7:0]       bip_byte;

   assign pyld_ready = (state_q == ST_PYLD);
   assign accept     = pyld_ready & i_pyld_data_valid;

`ifdef FRAME_BIP8_EN
   logic [7:0] bip_acc_q, bip_acc_d;
   logic [7:0] bip_last_q, bip_last_d;

   // BIP-8: fold accepted payload into the accumulator, hand it over at frame end.
   always_comb begin
      bip_acc_d  = bip_acc_q;
      bip_last_d = bip_last_q;
      if (frame_end) begin
         bip_last_d = bip_acc_q;
         bip_acc_d  = 8'h00;
      end else if (accept) begin
         bip_acc_d = bip_acc_q ^ i_pyld_data;
      end
   end

   // BIP-8 registers; an aborted frame discards its partial parity.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bip_acc_q  <= 8'h00;
         bip_last_q <= 8'h00;
      end else begin
         bip_acc_q  <= bip_acc_d;
         bip_last_q <= bip_last_d;
      end
   end

   assign bip_byte = bip_last_q;
`else
   assign bip_byte = 8'h00;
`endif

   // Overhead byte for the current position; rows other than 0 are all zero.
   always_comb begin
      oh_byte = 8'h00;
      if (row_q == '0) begin
         if (col_q < COL_W'(3)) begin
            oh_byte = FAS_A;
         end else if (col_q < COL_W'(6)) begin
            oh_byte = FAS_B;
         end else if (col_q == COL_W'(6)) begin
            oh_byte = i_arq_en ? 8'hFF : 8'h00;
         end else if (col_q == COL_W'(7)) begin
            oh_byte = mfas_q;
         end else if (col_q == COL_W'(8)) begin
            oh_byte = bip_byte;
         end
      end
   end

   // Framing FSM: next state, next position and next output byte.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      mfas_d    = mfas_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      fas_d     = 1'b0;
      sof_d     = 1'b0;
      orow_d    = orow_q;
      ocol_d    = ocol_q;
      emit      = 1'b0;
      frame_end = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Idle holds position at the frame origin and shows nothing valid.
            row_d  = '0;
            col_d  = '0;
            data_d = 8'h00;
            orow_d = '0;
            ocol_d = '0;
            if (i_en) begin
               state_d = ST_OH;
            end
         end

         ST_OH: begin
            emit   = 1'b1;
            data_d = oh_byte;
            if ((row_q == '0) && (col_q == '0)) begin
               fas_d = 1'b1;
               sof_d = 1'b1;
            end
            col_d = col_q + COL_W'(1);
            if (col_q == OH_LAST) begin
               state_d = ST_PYLD;
            end
         end

         ST_PYLD: begin
            // Position only moves when the client actually hands over a byte.
            if (accept) begin
               emit   = 1'b1;
               data_d = i_pyld_data;
               col_d  = col_q + COL_W'(1);
               if (col_q == PYLD_LAST) begin
                  state_d = ST_STUFF;
               end
            end
         end

         ST_STUFF: begin
            emit   = 1'b1;
            data_d = 8'h00;
            col_d  = '0;
            if (row_q == LAST_ROW) begin
               // Frame boundary: the only point where i_en is looked at again.
               row_d     = '0;
               frame_end = 1'b1;
               state_d   = i_en ? ST_OH : ST_IDLE;
            end else begin
               row_d   = row_q + ROW_W'(1);
               state_d = ST_OH;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (emit) begin
         valid_d = 1'b1;
         orow_d  = row_q;
         ocol_d  = col_q;
      end

      if (frame_end) begin
         mfas_d = mfas_q + 8'd1;
      end
   end

   // State, position, multiframe counter and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         mfas_q  <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         fas_q   <= 1'b0;
         sof_q   <= 1'b0;
         orow_q  <= '0;
         ocol_q  <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         mfas_q  <= mfas_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         fas_q   <= fas_d;
         sof_q   <= sof_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
      end
   end

   assign o_pyld_ready       = pyld_ready;
   assign o_frame_data       = data_q;
   assign o_frame_data_valid = valid_q;
   assign o_frame_data_fas   = fas_q;
   assign o_frame_sof        = sof_q;
   assign o_row_cnt          = orow_q;
   assign o_col_cnt          = ocol_q;
   assign o_mfas             = mfas_q;
   assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_frame_builder.sv
// tb_frame_builder: directed bench for frame_builder with a 2 x 24 frame,
// 16 overhead columns (payload at cols 16..22, stuff at col 23).
module tb_frame_builder;

   localparam int NR = 2;
   localparam int NC = 24;
   localparam int OC = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       arq_en;
   logic [7:0] pdata;
   logic       pvalid;

   logic       ready;
   logic [7:0] fdata;
   logic       fvalid;
   logic       fas;
   logic       sof;
   logic [0:0] row;
   logic [4:0] col;
   logic [7:0] mfas;
   logic [1:0] dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] pyld_ctr;
   logic [7:0] bip_run;
   logic [7:0] bip_exp;

   frame_builder #(
      .NUM_ROWS (NR),
      .NUM_COLS (NC),
      .OH_COLS  (OC)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_en               (en),
      .i_arq_en           (arq_en),
      .i_pyld_data        (pdata),
      .i_pyld_data_valid  (pvalid),
      .o_pyld_ready       (ready),
      .o_frame_data       (fdata),
      .o_frame_data_valid (fvalid),
      .o_frame_data_fas   (fas),
      .o_frame_sof        (sof),
      .o_row_cnt          (row),
      .o_col_cnt          (col),
      .o_mfas             (mfas),
      .o_dbg_state        (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " data"},  32'(fdata),     32'h00);
      chk({tag, " valid"}, 32'(fvalid),    32'd0);
      chk({tag, " fas"},   32'(fas),       32'd0);
      chk({tag, " sof"},   32'(sof),       32'd0);
      chk({tag, " row"},   32'(row),       32'd0);
      chk({tag, " col"},   32'(col),       32'd0);
      chk({tag, " mfas"},  32'(mfas),      32'h00);
      chk({tag, " ready"}, 32'(ready),     32'd0);
      chk({tag, " state"}, 32'(dbg_state), 32'd0);
   endtask

   // Drives and checks one frame starting from the cycle that emits (0,0).
   // mode 0: counting payload, always valid; 1: counting payload with a gap
   // before every payload byte; 2: all 0x5A; 3: 0x5A with the first byte 0x5B.
   // abort_col >= 0 asserts reset for one cycle when row 0 reaches that column.
   task automatic run_frame(input int mode, input logic arq, input logic [7:0] exp_mfas,
                            input logic drop_en, input int abort_col);
      int         pidx;
      logic [7:0] exp_d;
      logic       is_p;
      string      tg;
      pidx = 0;
      for (int r = 0; r < NR; r++) begin
         for (int c = 0; c < NC; c++) begin
            tg   = $sformatf("m%0d r%0d c%0d", mode, r, c);
            is_p = (c >= OC) && (c <= NC - 2);
            if ((r == 0) && (c == abort_col)) begin
               rst = 1'b1;
               tick();
               chk_reset({tg, " abort"});
               rst     = 1'b0;
               bip_run = 8'h00;
               bip_exp = 8'h00;
               return;
            end
            if (drop_en && (r == 1) && (c == 3)) en = 1'b0;
            arq_en = arq;
            if (is_p) begin
               if (mode == 1) begin
                  pvalid = 1'b0;
                  pdata  = 8'h55;
                  tick();
                  chk({tg, " gap valid"}, 32'(fvalid), 32'd0);
                  chk({tg, " gap col"},   32'(col),    32'(c - 1));
               end
               case (mode)
                  2:       pdata = 8'h5A;
                  3:       pdata = (pidx == 0) ? 8'h5B : 8'h5A;
                  default: pdata = pyld_ctr;
               endcase
               pvalid = 1'b1;
               exp_d  = pdata;
            end else begin
               pvalid = 1'b1;
               pdata  = 8'hAA;
               exp_d  = 8'h00;
               if (r == 0) begin
                  if (c <= 2)       exp_d = 8'hF6;
                  else if (c <= 5)  exp_d = 8'h28;
                  else if (c == 6)  exp_d = arq ? 8'hFF : 8'h00;
                  else if (c == 7)  exp_d = exp_mfas;
`ifdef FRAME_BIP8_EN
                  else if (c == 8)  exp_d = bip_exp;
`endif
               end
            end
            chk({tg, " ready"}, 32'(ready), 32'(is_p));
            tick();
            chk({tg, " valid"}, 32'(fvalid), 32'd1);
            chk({tg, " data"},  32'(fdata),  32'(exp_d));
            chk({tg, " row"},   32'(row),    32'(r));
            chk({tg, " col"},   32'(col),    32'(c));
            chk({tg, " fas"},   32'(fas),    32'((r == 0) && (c == 0)));
            chk({tg, " sof"},   32'(sof),    32'((r == 0) && (c == 0)));
            if (is_p) begin
               bip_run = bip_run ^ exp_d;
               if (mode <= 1) pyld_ctr = pyld_ctr + 8'd1;
               pidx++;
            end
         end
      end
      bip_exp = bip_run;
      bip_run = 8'h00;
   endtask

   // Directed sequence
   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      arq_en   = 1'b0;
      pvalid   = 1'b0;
      pdata    = 8'h00;
      pyld_ctr = 8'h01;
      bip_run  = 8'h00;
      bip_exp  = 8'h00;
      tick();
      tick();
      chk_reset("reset");

      rst = 1'b0;
      tick();
      chk("idle valid", 32'(fvalid), 32'd0);

      // Basic frame: ARQ set, continuous payload 0x01..0x0E.
      en = 1'b1;
      tick();
      chk("start valid", 32'(fvalid),    32'd0);
      chk("start state", 32'(dbg_state), 32'd1);
      run_frame(0, 1'b1, 8'h00, 1'b0, -1);

      // Back-to-back frame with payload gaps and 0xAA held during overhead.
      run_frame(1, 1'b0, 8'h01, 1'b0, -1);

      // Enable dropped at row 1, col 3: frame completes, then idle.
      run_frame(0, 1'b1, 8'h02, 1'b1, -1);
      tick();
      chk("drop idle valid", 32'(fvalid),    32'd0);
      chk("drop idle state", 32'(dbg_state), 32'd0);
      chk("drop idle mfas",  32'(mfas),      32'h03);
      tick();
      chk("drop idle valid2", 32'(fvalid), 32'd0);
      en = 1'b1;
      tick();
      chk("restart valid", 32'(fvalid), 32'd0);
      run_frame(0, 1'b0, 8'h03, 1'b0, -1);

      // Reset at row 0, col 20 of the next frame.
      run_frame(0, 1'b0, 8'h04, 1'b0, 20);
      tick();
      chk("post abort valid", 32'(fvalid), 32'd0);
      chk("post abort mfas",  32'(mfas),   32'h00);

      // MFAS wrap: col 7 runs 0x00..0xFF, 0x00, 0x01.
      for (int f = 0; f < 258; f++) begin
         run_frame(0, f[0], f[7:0], 1'b0, -1);
      end
      chk("mfas after wrap", 32'(mfas), 32'h02);

      // Parity frames: all 0x5A, then one 0x5B, then the frame carrying it.
      run_frame(2, 1'b0, 8'h02, 1'b0, -1);
      run_frame(3, 1'b0, 8'h03, 1'b0, -1);
      run_frame(0, 1'b0, 8'h04, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
